// File: rtl/alu_8bit_seq.sv
// alu_8bit_seq: multi-cycle 8-bit unsigned ALU (ADD, SUB, MUL, DIV) with a
// shared byte-wide operand bus and a registered byte-wide result bus.
//
// Protocol: BEGIN is sampled only in IDLE; the op_code is latched on that
// edge. Operand A is captured from inbus on the next edge and B on the edge
// after. END is high for one cycle (ADD/SUB) or two consecutive cycles
// (MUL/DIV, low byte/quotient first). outbus is 8'h00 whenever END is low.
// There is no back-pressure: the consumer must take the result while END=1.
`timescale 1ns/1ps
module alu_8bit_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       BEGIN,
    input  logic [1:0] op_code,
    input  logic [7:0] inbus,
    output logic [7:0] outbus,
    output logic       END
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_OUT_LO = 3'd4,
        S_OUT_HI = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // state_q is the observable controller state for checkers.
    state_t      state_q, state_d;
    logic [1:0]  op_reg;
    logic [7:0]  a_reg;     // dividend shifts out MSB-first; quotient shifts in
    logic [7:0]  b_reg;
    logic [7:0]  r_reg;     // division partial remainder
    logic [15:0] prod;      // multiply accumulator
    logic [2:0]  cnt;       // iteration counter 0..7
    logic [7:0]  hi_reg;    // second result byte, presented in OUT_HI

    logic        last;
    logic [15:0] mul_next;
    logic [8:0]  rem_sh;
    logic        rem_ge;
    logic [7:0]  r_next;
    logic [7:0]  a_next;
    logic [7:0]  lo_val;
    logic [7:0]  hi_val;
    logic        end_d;
    logic [7:0]  out_d;

    // One shift-add / restoring-division step and the final result bytes.
    // With B=0 every trial subtraction succeeds, so Q=8'hFF and R=A fall out
    // of the normal algorithm without a special case.
    always_comb begin
        mul_next = prod + (b_reg[cnt] ? ({8'h00, a_reg} << cnt) : 16'h0000);
        rem_sh   = {r_reg, a_reg[7]};
        rem_ge   = (rem_sh >= {1'b0, b_reg});
        r_next   = rem_ge ? (rem_sh[7:0] - b_reg) : rem_sh[7:0];
        a_next   = {a_reg[6:0], rem_ge};
        last     = (op_reg[1] == 1'b0) || (cnt == 3'd7);
        lo_val   = 8'h00;
        hi_val   = 8'h00;
        case (op_reg)
            OP_ADD: lo_val = a_reg + b_reg;
            OP_SUB: lo_val = a_reg - b_reg;
            OP_MUL: begin
                lo_val = mul_next[7:0];
                hi_val = mul_next[15:8];
            end
            OP_DIV: begin
                lo_val = a_next;
                hi_val = r_next;
            end
            default: lo_val = 8'h00;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Controller next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (BEGIN) state_d = S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC:   if (last) state_d = S_OUT_LO;
            S_OUT_LO: state_d = op_reg[1] ? S_OUT_HI : S_IDLE;
            S_OUT_HI: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs: END follows the OUT states.
    always_comb begin
        end_d = (state_d == S_OUT_LO) || (state_d == S_OUT_HI);
        out_d = 8'h00;
        if (state_q == S_EXEC && last)
            out_d = lo_val;
        else if (state_q == S_OUT_LO && op_reg[1])
            out_d = hi_reg;
    end

    // Output registers keep END/outbus glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            END    <= 1'b0;
            outbus <= 8'h00;
        end else begin
            END    <= end_d;
            outbus <= out_d;
        end
    end

    // Operand capture and iterative datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg <= 2'b00;
            a_reg  <= 8'h00;
            b_reg  <= 8'h00;
            r_reg  <= 8'h00;
            prod   <= 16'h0000;
            cnt    <= 3'd0;
            hi_reg <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE:   if (BEGIN) op_reg <= op_code;
                S_LOAD_A: a_reg <= inbus;
                S_LOAD_B: begin
                    b_reg <= inbus;
                    cnt   <= 3'd0;
                    prod  <= 16'h0000;
                    r_reg <= 8'h00;
                end
                S_EXEC: begin
                    cnt  <= cnt + 3'd1;
                    prod <= mul_next;
                    if (op_reg == OP_DIV) begin
                        a_reg <= a_next;
                        r_reg <= r_next;
                    end
                    if (last) hi_reg <= hi_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_8bit_seq.sv
// Bench for alu_8bit_seq: directed cases plus random operations, checked
// against an arithmetic reference model through an expected-value queue.
`timescale 1ns/1ps
module tb_alu_8bit_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       BEGIN;
    logic [1:0] op_code;
    logic [7:0] inbus;
    logic [7:0] outbus;
    logic       END;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    alu_8bit_seq dut (
        .clk     (clk),
        .reset   (reset),
        .BEGIN   (BEGIN),
        .op_code (op_code),
        .inbus   (inbus),
        .outbus  (outbus),
        .END     (END)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: plain unsigned arithmetic
    task automatic model_push(input logic [1:0] op, input int a, input int b);
        int p;
        case (op)
            2'b00: exp_q.push_back(8'((a + b) % 256));
            2'b01: exp_q.push_back(8'((a - b + 256) % 256));
            2'b10: begin
                p = a * b;
                exp_q.push_back(8'(p % 256));
                exp_q.push_back(8'(p / 256));
            end
            default: begin
                if (b == 0) begin
                    exp_q.push_back(8'hFF);
                    exp_q.push_back(8'(a));
                end else begin
                    exp_q.push_back(8'(a / b));
                    exp_q.push_back(8'(a % b));
                end
            end
        endcase
    endtask

    // drives BEGIN, A, B; returns #1 after the LOAD_B edge
    task automatic start_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                            input bit hold);
        @(negedge clk);
        BEGIN   = 1'b1;
        op_code = op;
        inbus   = 8'($urandom);
        @(negedge clk);
        inbus   = a;
        op_code = 2'($urandom);
        BEGIN   = hold ? 1'b1 : 1'($urandom);
        @(negedge clk);
        inbus   = b;
        BEGIN   = hold ? 1'b1 : 1'($urandom);
        @(posedge clk);
        #1;
        inbus   = 8'($urandom);
        op_code = 2'($urandom);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input bit hold, input string tag);
        int k;
        logic [7:0] e;
        model_push(op, a, b);
        start_op(op, a, b, hold);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (!END) check({tag, "_quiet"}, outbus, 0);
        end while (!END && k < 20);
        check({tag, "_latency"}, k, op[1] ? 8 : 1);
        if (!END) begin
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            check({tag, "_lo"}, outbus, e);
            if (op[1]) begin
                @(posedge clk);
                #1;
                check({tag, "_end_hi"}, END, 1);
                e = exp_q.pop_front();
                check({tag, "_hi"}, outbus, e);
            end
            @(posedge clk);
            #1;
            check({tag, "_end_off"}, END, 0);
            check({tag, "_out_off"}, outbus, 0);
        end
        BEGIN = hold;
    endtask

    task automatic abort_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                            input int edges, input bit expect_end, input string tag);
        start_op(op, a, b, 1'b0);
        repeat (edges) @(posedge clk);
        @(negedge clk);
        check({tag, "_pre_end"}, END, expect_end);
        reset = 1'b1;
        BEGIN = 1'b0;
        #1;
        check({tag, "_rst_end"}, END, 0);
        check({tag, "_rst_out"}, outbus, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold;
        reset   = 1'b1;
        BEGIN   = 1'b0;
        op_code = 2'b00;
        inbus   = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_end", END, 0);
        check("reset_out", outbus, 0);
        reset = 1'b0;

        run_op(2'b00, 8'd3,   8'd2,   1'b0, "add_3_2");
        run_op(2'b01, 8'd2,   8'd3,   1'b0, "sub_wrap");
        run_op(2'b00, 8'd200, 8'd100, 1'b0, "add_wrap");
        run_op(2'b00, 8'd255, 8'd1,   1'b0, "add_255_1");
        run_op(2'b10, 8'd7,   8'd3,   1'b0, "mul_7_3");
        run_op(2'b10, 8'd255, 8'd255, 1'b0, "mul_ff_ff");
        run_op(2'b11, 8'd100, 8'd7,   1'b0, "div_100_7");
        run_op(2'b11, 8'd9,   8'd0,   1'b0, "div_by_0");
        run_op(2'b11, 8'd5,   8'd200, 1'b0, "div_small");

        // BEGIN low in IDLE keeps the unit idle
        repeat (4) begin
            @(posedge clk);
            #1;
            check("idle_end", END, 0);
        end

        abort_op(2'b10, 8'd77, 8'd99, 4, 1'b0, "abort_mul");
        run_op(2'b00, 8'd1, 8'd1, 1'b0, "after_abort");
        abort_op(2'b11, 8'd50, 8'd3, 8, 1'b1, "abort_div_out");
        run_op(2'b01, 8'd0, 8'd1, 1'b0, "sub_0_1");

        // back-to-back with BEGIN held high
        run_op(2'b10, 8'd13,  8'd11, 1'b1, "b2b_mul");
        run_op(2'b11, 8'd200, 8'd9,  1'b1, "b2b_div");
        run_op(2'b00, 8'd5,   8'd9,  1'b0, "b2b_add");

        for (int i = 0; i < 60; i++) begin
            hold = (i == 59) ? 1'b0 : 1'($urandom_range(0, 1));
            run_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), hold, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
